// File: rtl/inst_fetch_pkg.sv
// Shared constants for the instruction fetch unit: control-flow opcodes,
// cache geometry default, reset PC and the fetch FSM state type.
package inst_fetch_pkg;

    localparam int          ICACHE_IDX_BITS_DEF = 4;
    localparam logic [31:0] RESET_PC_DEF        = 32'h0000_0000;

    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    typedef enum logic [1:0] {
        ST_RUN,
        ST_MISS,
        ST_WAIT_REDIR
    } fetch_state_e;

    function automatic logic is_ctrl_flow(input logic [31:0] inst);
        return (inst[6:0] == OPC_JAL) || (inst[6:0] == OPC_JALR) ||
               (inst[6:0] == OPC_BRANCH);
    endfunction

endpackage

// File: rtl/inst_fetch_icache.sv
// Direct-mapped instruction cache, one 32-bit word per line.
// Combinational lookup, synchronous fill, asynchronous clear of valid bits.
module icache_dm
    import inst_fetch_pkg::*;
#(
    parameter int IDX_BITS = ICACHE_IDX_BITS_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:2] lookup_addr,
    output logic        hit,
    output logic [31:0] rd_data,
    input  logic        fill_en,
    input  logic [31:2] fill_addr,
    input  logic [31:0] fill_data
);

    localparam int LINES    = 1 << IDX_BITS;
    localparam int TAG_BITS = 30 - IDX_BITS;

    logic [LINES-1:0]    valid;
    logic [TAG_BITS-1:0] tag_mem  [LINES];
    logic [31:0]         data_mem [LINES];

    logic [IDX_BITS-1:0] lookup_idx;
    logic [IDX_BITS-1:0] fill_idx;

    assign lookup_idx = lookup_addr[IDX_BITS+1:2];
    assign fill_idx   = fill_addr[IDX_BITS+1:2];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid <= '0;
        end else if (fill_en) begin
            valid[fill_idx] <= 1'b1;
        end
    end

    // NOTE: tag/data arrays carry no reset; the valid bits alone decide
    // whether their contents mean anything, so they map onto plain RAM.
    always_ff @(posedge clk) begin
        if (fill_en) begin
            tag_mem[fill_idx]  <= fill_addr[31:IDX_BITS+2];
            data_mem[fill_idx] <= fill_data;
        end
    end

    assign hit     = valid[lookup_idx] && (tag_mem[lookup_idx] == lookup_addr[31:IDX_BITS+2]);
    assign rd_data = data_mem[lookup_idx];

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch unit: presents PC/instruction to the decoder, refills
// cache misses over a word-wide request/response port, stalls on control flow.
module inst_fetch
    import inst_fetch_pkg::*;
#(
    parameter int          ICACHE_IDX_BITS = ICACHE_IDX_BITS_DEF,
    parameter logic [31:0] RESET_PC        = RESET_PC_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        need_inst,
    input  logic        clear_inst,
    input  logic [31:0] if_addr,
    input  logic        rob_clear,
    input  logic [31:0] rob_new_pc,
    output logic [31:0] PC,
    output logic [31:0] inst_in,
    output logic        instcache_ready_out,
    output logic        mem_req_valid,
    output logic [31:0] mem_req_addr,
    input  logic        mem_resp_valid,
    input  logic [31:0] mem_resp_data
);

    fetch_state_e state;
    logic [31:0]  fetch_pc;
    logic         take;
    logic         slot_free;
    logic         cache_hit;
    logic [31:0]  cache_data;
    logic         fill_en;

    assign take      = instcache_ready_out && need_inst;
    assign slot_free = !instcache_ready_out || take;
    assign fill_en   = rdy && (state == ST_MISS) && mem_resp_valid;

    icache_dm #(
        .IDX_BITS (ICACHE_IDX_BITS)
    ) u_icache (
        .clk         (clk),
        .rst         (rst),
        .lookup_addr (fetch_pc[31:2]),
        .hit         (cache_hit),
        .rd_data     (cache_data),
        .fill_en     (fill_en),
        .fill_addr   (mem_req_addr[31:2]),
        .fill_data   (mem_resp_data)
    );

    // NOTE: all state is updated with non-blocking assignments so every
    // branch below reads the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state               <= ST_RUN;
            fetch_pc            <= RESET_PC;
            PC                  <= RESET_PC;
            inst_in             <= '0;
            instcache_ready_out <= 1'b0;
            mem_req_valid       <= 1'b0;
            mem_req_addr        <= '0;
        end else if (rdy) begin
            // A refill always completes into the cache, even if a redirect
            // has since moved fetch_pc elsewhere; RUN then re-looks up.
            if (state == ST_MISS && mem_resp_valid) begin
                mem_req_valid <= 1'b0;
                state         <= ST_RUN;
            end

            if (rob_clear || clear_inst) begin
                fetch_pc            <= rob_clear ? rob_new_pc : if_addr;
                instcache_ready_out <= 1'b0;
                if (state == ST_WAIT_REDIR) begin
                    state <= ST_RUN;
                end
            end else if (state == ST_RUN && slot_free) begin
                if (take && is_ctrl_flow(inst_in)) begin
                    // Control flow handed to the decoder: wait for its redirect.
                    instcache_ready_out <= 1'b0;
                    state               <= ST_WAIT_REDIR;
                end else if (cache_hit) begin
                    PC                  <= fetch_pc;
                    inst_in             <= cache_data;
                    instcache_ready_out <= 1'b1;
                    fetch_pc            <= fetch_pc + 32'd4;
                end else begin
                    instcache_ready_out <= 1'b0;
                    mem_req_valid       <= 1'b1;
                    mem_req_addr        <= {fetch_pc[31:2], 2'b00};
                    state               <= ST_MISS;
                end
            end
        end
    end

endmodule

// File: tb/tb_inst_fetch.sv
// Self-checking bench for inst_fetch: memory responder with request scoreboard,
// take monitor with instruction scoreboard, a cycle table and directed sequences.
module tb_inst_fetch;

    localparam int MEM_LAT = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        rdy = 1'b1;
    logic        need_inst = 1'b0;
    logic        clear_inst = 1'b0;
    logic [31:0] if_addr = '0;
    logic        rob_clear = 1'b0;
    logic [31:0] rob_new_pc = '0;
    logic        mem_resp_valid = 1'b0;
    logic [31:0] mem_resp_data = '0;
    logic [31:0] PC;
    logic [31:0] inst_in;
    logic        instcache_ready_out;
    logic        mem_req_valid;
    logic [31:0] mem_req_addr;

    int tests = 0;
    int failures = 0;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
    } inst_t;

    typedef struct {
        logic        need;
        logic        clr;
        logic [31:0] addr;
        logic        exp_ready;
        logic [31:0] exp_pc;
    } vec_t;

    logic [31:0] exp_req[$];
    inst_t       exp_inst[$];
    vec_t        vecs[13];

    inst_fetch dut (
        .clk                 (clk),
        .rst                 (rst),
        .rdy                 (rdy),
        .need_inst           (need_inst),
        .clear_inst          (clear_inst),
        .if_addr             (if_addr),
        .rob_clear           (rob_clear),
        .rob_new_pc          (rob_new_pc),
        .PC                  (PC),
        .inst_in             (inst_in),
        .instcache_ready_out (instcache_ready_out),
        .mem_req_valid       (mem_req_valid),
        .mem_req_addr        (mem_req_addr),
        .mem_resp_valid      (mem_resp_valid),
        .mem_resp_data       (mem_resp_data)
    );

    always #5 clk = ~clk;

    // Backing memory: JAL at 0x10, nops at 0..8, address-tagged ALU ops elsewhere.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h10) return 32'h0080_006f;
        if (a < 32'hC) return 32'h0000_0013;
        return {a[24:0], 7'h13};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic flag(input string name, input logic [31:0] act);
        tests++;
        failures++;
        $display("FAIL %s: got %h with nothing expected", name, act);
    endtask

    task automatic push_inst(input logic [31:0] pc);
        inst_t e;
        e.pc   = pc;
        e.inst = mem_word(pc);
        exp_inst.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_drain(input string name, input int max);
        int n = 0;
        while (exp_inst.size() != 0 && n < max) begin
            @(negedge clk);
            n++;
        end
        check({name, "_drained"}, exp_inst.size(), 0);
        tick();
    endtask

    task automatic wait_ready(input string name, input int max);
        int n = 0;
        @(negedge clk);
        while (!instcache_ready_out && n < max) begin
            @(negedge clk);
            n++;
        end
        check({name, "_ready"}, instcache_ready_out, 1);
    endtask

    // Memory responder: fixed latency, one-cycle response, checks request order.
    initial begin
        int cnt = 0;
        forever begin
            tick();
            if (!rst) begin
                mem_resp_valid = 1'b0;
                cnt = 0;
            end else if (mem_resp_valid) begin
                mem_resp_valid = 1'b0;
            end else if (rdy && mem_req_valid) begin
                if (cnt == MEM_LAT - 1) begin
                    cnt = 0;
                    mem_resp_valid = 1'b1;
                    mem_resp_data  = mem_word(mem_req_addr);
                    if (exp_req.size() == 0) flag("req_unexpected", mem_req_addr);
                    else check("req_addr", mem_req_addr, exp_req.pop_front());
                end else begin
                    cnt++;
                end
            end else begin
                cnt = 0;
            end
        end
    end

    // Take monitor: every instruction the decoder accepts must match the scoreboard.
    always @(negedge clk) begin
        inst_t e;
        if (rst) begin
            if (mem_req_valid) check("ready_low_in_miss", instcache_ready_out, 0);
            if (instcache_ready_out && need_inst && !rob_clear) begin
                if (exp_inst.size() == 0) begin
                    flag("take_unexpected", PC);
                end else begin
                    e = exp_inst.pop_front();
                    check("take_pc", PC, e.pc);
                    check("take_inst", inst_in, e.inst);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // need, clear, if_addr, exp_ready, exp_pc  (starts in WAIT_REDIR after JAL)
        vecs[0]  = '{1'b1, 1'b1, 32'h00, 1'b0, 32'h00};
        vecs[1]  = '{1'b1, 1'b0, 32'h00, 1'b0, 32'h00};
        vecs[2]  = '{1'b1, 1'b0, 32'h00, 1'b1, 32'h00};
        vecs[3]  = '{1'b0, 1'b0, 32'h00, 1'b1, 32'h04};
        vecs[4]  = '{1'b0, 1'b0, 32'h00, 1'b1, 32'h04};
        vecs[5]  = '{1'b0, 1'b0, 32'h00, 1'b1, 32'h04};
        vecs[6]  = '{1'b1, 1'b0, 32'h00, 1'b1, 32'h04};
        vecs[7]  = '{1'b1, 1'b0, 32'h00, 1'b1, 32'h08};
        vecs[8]  = '{1'b1, 1'b0, 32'h00, 1'b1, 32'h0C};
        vecs[9]  = '{1'b1, 1'b0, 32'h00, 1'b1, 32'h10};
        vecs[10] = '{1'b1, 1'b0, 32'h00, 1'b0, 32'h00};
        vecs[11] = '{1'b1, 1'b1, 32'h18, 1'b0, 32'h00};
        vecs[12] = '{1'b1, 1'b0, 32'h00, 1'b0, 32'h00};

        // Reset values
        #12;
        check("rst_pc", PC, 32'h0);
        check("rst_inst", inst_in, 32'h0);
        check("rst_ready", instcache_ready_out, 0);
        check("rst_req_valid", mem_req_valid, 0);
        check("rst_req_addr", mem_req_addr, 32'h0);

        // Cold start: every fetch misses until the JAL at 0x10 stalls the unit
        foreach (exp_req[i]) exp_req.delete(i);
        for (int a = 0; a <= 16; a += 4) begin
            exp_req.push_back(a);
            push_inst(a);
        end
        tick();
        need_inst = 1'b1;
        rst = 1'b1;
        wait_drain("cold", 200);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("jal_stall_ready", instcache_ready_out, 0);
            check("jal_stall_req", mem_req_valid, 0);
            tick();
        end

        // Warm refetch from 0 with a 3-cycle decoder stall, then JAL redirect to 0x18
        push_inst(32'h00);
        push_inst(32'h04);
        push_inst(32'h08);
        push_inst(32'h0C);
        push_inst(32'h10);
        for (int i = 0; i < 13; i++) begin
            need_inst  = vecs[i].need;
            clear_inst = vecs[i].clr;
            if_addr    = vecs[i].addr;
            @(negedge clk);
            check($sformatf("vec%0d_ready", i), instcache_ready_out, vecs[i].exp_ready);
            check($sformatf("vec%0d_req", i), mem_req_valid, 0);
            if (vecs[i].exp_ready) begin
                check($sformatf("vec%0d_pc", i), PC, vecs[i].exp_pc);
                check($sformatf("vec%0d_inst", i), inst_in, mem_word(vecs[i].exp_pc));
            end
            tick();
        end

        // Continue from 0x18; ROB flush to 0x40 while the 0x20 refill is outstanding
        exp_req.push_back(32'h18);
        exp_req.push_back(32'h1C);
        exp_req.push_back(32'h20);
        push_inst(32'h18);
        push_inst(32'h1C);
        begin
            int n = 0;
            @(negedge clk);
            while (!(mem_req_valid && mem_req_addr == 32'h20) && n < 60) begin
                @(negedge clk);
                n++;
            end
            check("miss20_seen", mem_req_addr, 32'h20);
        end
        tick();
        rob_clear  = 1'b1;
        rob_new_pc = 32'h40;
        need_inst  = 1'b0;
        exp_req.push_back(32'h40);
        tick();
        rob_clear = 1'b0;
        wait_ready("rob_miss", 40);
        check("rob_miss_pc", PC, 32'h40);
        check("rob_miss_inst", inst_in, mem_word(32'h40));
        tick();

        // Line 0x20 was filled by the absorbed refill: redirect there hits
        rob_clear  = 1'b1;
        rob_new_pc = 32'h20;
        @(negedge clk);
        tick();
        rob_clear = 1'b0;
        @(negedge clk);
        check("hit20_gap_ready", instcache_ready_out, 0);
        check("hit20_gap_req", mem_req_valid, 0);
        tick();
        @(negedge clk);
        check("hit20_ready", instcache_ready_out, 1);
        check("hit20_pc", PC, 32'h20);
        check("hit20_inst", inst_in, mem_word(32'h20));
        check("hit20_req", mem_req_valid, 0);
        tick();

        // rdy=0 freezes everything, even a pending ROB flush
        rdy        = 1'b0;
        rob_clear  = 1'b1;
        rob_new_pc = 32'h500;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("frozen_ready", instcache_ready_out, 1);
            check("frozen_pc", PC, 32'h20);
            tick();
        end
        rdy       = 1'b1;
        rob_clear = 1'b0;
        @(negedge clk);
        check("unfrozen_pc", PC, 32'h20);
        tick();

        // Simultaneous decoder and ROB redirect: ROB target wins
        clear_inst = 1'b1;
        if_addr    = 32'h100;
        rob_clear  = 1'b1;
        rob_new_pc = 32'h200;
        exp_req.push_back(32'h200);
        tick();
        clear_inst = 1'b0;
        rob_clear  = 1'b0;
        wait_ready("dual", 40);
        check("dual_pc", PC, 32'h200);
        check("dual_inst", inst_in, mem_word(32'h200));
        tick();

        // Wrap past 2^32; the take of 0x200 coinciding with the flush is dropped
        rob_clear  = 1'b1;
        rob_new_pc = 32'hFFFF_FFFC;
        need_inst  = 1'b1;
        exp_req.push_back(32'hFFFF_FFFC);
        exp_req.push_back(32'h0);
        push_inst(32'hFFFF_FFFC);
        for (int a = 0; a <= 16; a += 4) push_inst(a);
        tick();
        rob_clear = 1'b0;
        wait_drain("wrap", 200);
        @(negedge clk);
        check("wrap_jal_stall", instcache_ready_out, 0);
        tick();

        // Asynchronous reset in the middle of a miss
        clear_inst = 1'b1;
        if_addr    = 32'h300;
        need_inst  = 1'b0;
        tick();
        clear_inst = 1'b0;
        begin
            int n = 0;
            @(negedge clk);
            while (!mem_req_valid && n < 20) begin
                @(negedge clk);
                n++;
            end
            check("miss300_req", mem_req_addr, 32'h300);
        end
        #2;
        rst = 1'b0;
        #1;
        check("mid_rst_pc", PC, 32'h0);
        check("mid_rst_inst", inst_in, 32'h0);
        check("mid_rst_ready", instcache_ready_out, 0);
        check("mid_rst_req_valid", mem_req_valid, 0);
        check("mid_rst_req_addr", mem_req_addr, 32'h0);
        tick();
        tick();
        rst = 1'b1;
        exp_req.push_back(32'h0);
        wait_ready("post_rst", 40);
        check("post_rst_pc", PC, 32'h0);
        check("post_rst_inst", inst_in, mem_word(32'h0));
        tick();
        tick();

        check("req_queue_empty", exp_req.size(), 0);
        check("inst_queue_empty", exp_inst.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule

// File: doc/inst_fetch.md
Name: inst_fetch

Overview:
- Instruction fetch unit: the producer end of the fetch→decoder interface (PC, inst_in, instcache_ready_out / need_inst, clear_inst, if_addr).
- Holds a direct-mapped one-word-per-line instruction cache and refills misses through a word-wide memory request handshake.
- Predecodes control-flow opcodes, stalls after issuing one until the decoder's redirect arrives, and accepts ROB mispredict flushes.

Parameters:
- ICACHE_IDX_BITS, 4, log2 of cache lines (16 lines × 32-bit word).
- RESET_PC, 32'h0, first fetch address after reset.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- rdy  in  1  global enable; when 0 all state holds
- need_inst  in  1  decoder: 0 = presented instruction not taken this cycle
- clear_inst  in  1  decoder redirect strobe, one cycle
- if_addr  in  32  decoder redirect target
- rob_clear  in  1  ROB mispredict flush
- rob_new_pc  in  32  ROB correct PC
- PC  out  32  address of presented instruction
- inst_in  out  32  presented instruction
- instcache_ready_out  out  1  PC/inst_in valid
- mem_req_valid  out  1  refill request
- mem_req_addr  out  32  word-aligned refill address
- mem_resp_valid  in  1  refill data valid, one cycle
- mem_resp_data  in  32  refill word

Behaviour:
- Reset (rst=0, async): PC=RESET_PC, inst_in=0, instcache_ready_out=0, mem_req_valid=0, mem_req_addr=0, all line valid bits 0, fetch_pc=RESET_PC, state RUN.
- Address split: idx=fetch_pc[ICACHE_IDX_BITS+1:2], tag=fetch_pc[31:ICACHE_IDX_BITS+2]. fetch_pc[1:0] is ignored, treated as 0.
- Handshake: an instruction is taken in a cycle with instcache_ready_out=1 and need_inst=1. While need_inst=0, PC and inst_in hold stable.
- RUN state:
  - If the output slot is empty or taken this cycle, look up fetch_pc.
  - Hit: next cycle PC=fetch_pc, inst_in=line data, ready=1, fetch_pc+=4. Back-to-back hits sustain 1 instr/cycle.
  - Miss: ready drops to 0 once the slot is taken; mem_req_valid=1, mem_req_addr={fetch_pc[31:2],2'b0}; go to MISS.
- MISS state:
  - mem_req_valid and mem_req_addr held until mem_resp_valid. Latency ≥1, unbounded.
  - On response: fill the line (valid=1, tag, data); mem_req_valid=0 the same edge; return to RUN, which re-looks up and hits.
- Predecode: when the taken instruction's opcode[6:0] is 1101111, 1100111 or 1100011, ready→0 next cycle and state goes to WAIT_REDIR. No further instruction is presented.
- WAIT_REDIR: on clear_inst=1, fetch_pc=if_addr; go to RUN.
- Redirect in RUN or MISS:
  - clear_inst, or rob_clear in any state, sets ready=0 next cycle and fetch_pc=target.
  - Outstanding refill: the request is kept until the response, the response still fills the cache, nothing stale is presented, then RUN continues from the new fetch_pc.
- Simultaneous events:
  - rob_clear and clear_inst in the same cycle: rob_new_pc wins.
  - rob_clear in the same cycle as a take: the take is discarded.
- PC continuity: a new instruction is always presented with a PC different from the previous one, except after a redirect to the same address. Because ready drops for ≥1 cycle first, the decoder's last-address check still works.
- Width: fetch_pc+4 wraps modulo 2^32.
- rdy=0: no state, output, or memory-request change; mem_resp_valid is not asserted by memory while rdy=0.

Decomposition:
- Shared const package: opcode localparams (JAL, JALR, BRANCH), ICACHE_IDX_BITS default, RESET_PC.
- One sub-module, icache_dm: valid/tag/data arrays, combinational hit/data read, synchronous fill port, async active-low clear of valid bits.
- The FSM (RUN, MISS, WAIT_REDIR) lives in inst_fetch.

Test Plan:
- Cold start, memory returns 32'h00000013 for 0,4,8 with 3-cycle latency → requests at 0,4,8 in order; instructions presented at PC 0,4,8 each after its fill; ready is 0 during each MISS.
- Refetch of 0..8 after a redirect to 0 (warm cache) with need_inst=1 → PC 0,4,8 on consecutive cycles, no mem_req_valid.
- need_inst=0 for 3 cycles while presenting PC=4 → PC=4 and inst_in stable for 3 cycles; PC=8 appears the cycle after need_inst=1.
- JAL 32'h0080006f at PC=0x10 taken → ready=0 from next cycle. Clear_inst with if_addr=0x18 after 2 cycles → next presented PC=0x18; PC 0x14 never presented.
- rob_clear with rob_new_pc=0x40 during a MISS on 0x20 → fill for 0x20 is absorbed and line 0x20 is valid; next request is 0x40; first presented PC=0x40.
- clear_inst (if_addr=0x100) and rob_clear (rob_new_pc=0x200) in the same cycle → next presented PC=0x200.
- Deassert rst mid-MISS → outputs return to reset values immediately; after release, the first request is to RESET_PC.
